mips_cpu_muldiv: RTL and testbench
==================================

Name: mips_cpu_muldiv

Overview:
Multiply/divide unit alongside the ALU in the execute stage. Consumes the same decoded operands (rs value on a, rt value on b) and owns the architectural HI/LO registers. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiplies complete in a single cycle; divides use a 32-iteration restoring divider, with busy telling the control unit to stall MFHI/MFLO and further muldiv ops.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported and verified.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled on rising clk edge, honoured only in IDLE
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
a  input  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO source)
b  input  WIDTH  rt operand (divisor/multiplier)
busy  output  1  divide in progress; start ignored while high
done  output  1  one-cycle pulse: HI/LO updated by the completed op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-divide): state=IDLE, hi=0, lo=0, busy=0, done=0, divider datapath cleared. Any in-flight divide is abandoned with no HI/LO update.
- States: IDLE, DIV_RUN, DIV_FIX.
- IDLE, start=1 at edge E0:
  - MULT: {hi,lo} <= signed 32x32 -> 64-bit product at E0; done=1 for the cycle after E0. busy stays 0.
  - MULTU: as MULT, unsigned.
  - MTHI: hi <= a at E0. MTLO: lo <= a at E0. The other register is unchanged. done is not pulsed.
  - DIV/DIVU: operands latched; for DIV, magnitudes are taken and the signs are recorded. State -> DIV_RUN, busy=1 from E0, iteration counter=0.
  - op 6/7: no effect.
- DIV_RUN: one restoring step per edge (shift remainder left, bring in the next dividend bit, conditionally subtract the divisor, shift in a quotient bit). Iterations run at E1..E32. At E32, state -> DIV_FIX.
- DIV_FIX, at E33:
  - Sign correction for DIV: quotient is negated if the operand signs differ (truncation toward zero); remainder takes the sign of the dividend.
  - lo <= quotient, hi <= remainder, done=1 for one cycle, busy=0, state -> IDLE.
  - busy is high for exactly 33 cycles (E0..E33).
- Divide by zero (b=0) is defined, not trapped, and runs the full 33 cycles:
  - lo=32'hFFFFFFFF, hi=a, for both DIV and DIVU.
- DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- HI/LO hold their values when unwritten. hi/lo outputs change only at the edges defined above, never mid-divide.
- start while busy (including MTHI/MTLO): ignored with no effect. The control unit guarantees a stall.
- start in the cycle where done=1 (state already IDLE): accepted normally, so ops can run back-to-back.
- a/b are don't-care after E0 during a divide.

Test Plan:
- Reset with start=1, op=MULT, a=3, b=4 held -> hi=lo=0, busy=0, done=0. Release reset, then one edge -> hi=0, lo=12, done pulse.
- MULT a=32'hFFFFFFFE (-2), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. MULTU with the same operands -> hi=2, lo=32'hFFFFFFFA.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> busy high for 33 cycles, then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1), done for 1 cycle. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5. DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- During a DIV: pulse start with MTHI a=32'hDEAD at cycle 10 -> ignored, and the final hi equals the remainder. Then MTHI 32'hDEAD and MTLO 32'hBEEF on consecutive cycles -> hi=32'hDEAD, lo=32'hBEEF.
- Assert reset at cycle 20 of a DIV -> busy=0 and hi=lo=0 immediately, with no done pulse afterwards. A DIVU issued in the same cycle as a MULT's done pulse is accepted.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Single-cycle multiplies; 32-step restoring divide with a final sign-fix cycle.
module mips_cpu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   // state     | meaning
   // S_IDLE    | accepts start; multiplies and MTHI/MTLO complete here
   // S_DIV_RUN | one restoring divide step per clock, WIDTH steps
   // S_DIV_FIX | sign correction, HI/LO write, done pulse
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DIV_RUN = 2'd1;
   localparam logic [1:0] S_DIV_FIX = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [1:0]         state;
   logic [CW-1:0]      step;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   divisor;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;

   logic signed [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic                      is_signed;
   logic [WIDTH-1:0]          a_mag;
   logic [WIDTH-1:0]          b_mag;
   logic [WIDTH:0]            rem_shift;
   logic [WIDTH:0]            diff;
   logic                      fits;

   assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   assign is_signed = (op == OP_DIV);
   assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

   // quo doubles as the dividend shift register: its MSB feeds the remainder
   assign rem_shift = {rem, quo[WIDTH-1]};
   assign diff      = rem_shift - {1'b0, divisor};
   assign fits      = ~diff[WIDTH];

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         step     <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT: begin
                        {hi, lo} <= prod_s;
                        done     <= 1'b1;
                     end
                     OP_MULTU: begin
                        {hi, lo} <= prod_u;
                        done     <= 1'b1;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     OP_DIV, OP_DIVU: begin
                        rem      <= '0;
                        quo      <= a_mag;
                        divisor  <= b_mag;
                        neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= is_signed && a[WIDTH-1];
                        div_zero <= (b == '0);
                        step     <= '0;
                        state    <= S_DIV_RUN;
                     end
                     default: ;
                  endcase
               end
            end
            S_DIV_RUN: begin
               rem  <= fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
               quo  <= {quo[WIDTH-2:0], fits};
               step <= step + 1'b1;
               if (step == LAST_STEP) state <= S_DIV_FIX;
            end
            S_DIV_FIX: begin
               // remainder already equals a for b=0, only the quotient needs forcing
               lo    <= div_zero ? '1 : (neg_q ? -quo : quo);
               hi    <= neg_r ? -rem : rem;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Randomized self-checking bench for mips_cpu_muldiv against an arithmetic HI/LO model.
module tb_mips_cpu_muldiv;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;
   logic [31:0] mh, ml;

   mips_cpu_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] eh, output logic [31:0] el);
      longint      ps;
      logic [63:0] pu;
      int          sx, sy;
      eh = mh;
      el = ml;
      case (o)
         3'd0: begin
            ps = longint'($signed(x)) * longint'($signed(y));
            {eh, el} = 64'(ps);
         end
         3'd1: begin
            pu = 64'(x) * 64'(y);
            {eh, el} = pu;
         end
         3'd2, 3'd3: begin
            if (y == 32'd0) begin
               el = 32'hFFFFFFFF;
               eh = x;
            end else if (o == 3'd3) begin
               el = x / y;
               eh = x % y;
            end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               el = 32'h80000000;
               eh = 32'd0;
            end else begin
               sx = $signed(x);
               sy = $signed(y);
               el = 32'(sx / sy);
               eh = 32'(sx % sy);
            end
         end
         3'd4: eh = x;
         3'd5: el = x;
         default: ;
      endcase
   endtask

   // Issue at a negedge; returns at the negedge where the result is visible.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit inject);
      logic [31:0] eh, el;
      int n;
      bit stable;
      model(o, x, y, eh, el);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      if (o == 3'd2 || o == 3'd3) begin
         n = 0;
         stable = 1'b1;
         while (busy === 1'b1 && n < 40) begin
            n++;
            if (hi !== mh || lo !== ml) stable = 1'b0;
            if (inject && n == 10) begin
               op = 3'd4; a = 32'hDEAD; start = 1'b1;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
         end
         start = 1'b0;
         chk("div_busy_cycles", 32'(n), 32'd33);
         chk("div_hilo_stable", 32'(stable), 32'd1);
         chk("div_done", 32'(done), 32'd1);
      end else begin
         chk("op_busy", 32'(busy), 32'd0);
         chk("op_done", 32'(done), (o <= 3'd1) ? 32'd1 : 32'd0);
      end
      chk("hi", hi, eh);
      chk("lo", lo, el);
      mh = eh;
      ml = el;
   endtask

   task automatic idle_cycle();
      start = 1'b0;
      @(negedge clk);
      chk("done_width", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int bad;
      logic [2:0]  ro;
      logic [31:0] rx, ry;

      reset = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("first_mult_hi", hi, 32'd0);
      chk("first_mult_lo", lo, 32'd12);
      chk("first_mult_done", 32'(done), 32'd1);
      mh = 32'd0; ml = 32'd12;
      idle_cycle();

      run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
      chk("mult_neg_hi", hi, 32'hFFFFFFFF);
      run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      chk("multu_hi", hi, 32'd2);
      // DIVU issued in the cycle MULTU's done is high
      run_op(3'd3, 32'd100, 32'd7, 1'b0);
      chk("divu_lo", lo, 32'd14);
      idle_cycle();
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
      chk("div_neg_lo", lo, 32'hFFFFFFFD);
      chk("div_neg_hi", hi, 32'hFFFFFFFF);
      idle_cycle();
      run_op(3'd3, 32'd5, 32'd0, 1'b0);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(3'd2, 32'hFFFFFF85, 32'd0, 1'b0);
      run_op(3'd2, 32'd1000, 32'd7, 1'b1);
      chk("inject_hi_is_rem", hi, 32'd6);
      run_op(3'd4, 32'hDEAD, 32'd0, 1'b0);
      run_op(3'd5, 32'hBEEF, 32'd0, 1'b0);
      chk("mthi_kept", hi, 32'hDEAD);
      idle_cycle();

      op = 3'd2; a = 32'd123456; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      mh = 32'd0; ml = 32'd0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
      end
      chk("midrst_quiet", 32'(bad), 32'd0);

      for (int i = 0; i < 60; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = $urandom;
         case ($urandom_range(0, 7))
            0: ry = 32'd0;
            1: ry = 32'($urandom_range(1, 20));
            2: ry = 32'hFFFFFFFF;
            default: ry = $urandom;
         endcase
         run_op(ro, rx, ry, 1'b0);
         if ($urandom_range(0, 1) == 0) idle_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
